morse_sequence_consumer: RTL and testbench
==========================================

# morse_sequence_consumer

Receive-side counterpart of the Morse producer path. Accepts each packed 10-bit symbol sequence handed over on the producer's `sent` strobe, decodes it to a 7-bit ASCII character (A–Z, 0–9), and buffers the characters, plus a space on end-of-sequence, in a FIFO. The FIFO is drained by a downstream display/UART stage over a valid/ready handshake. The block sits on the same system clock as the producer and tolerates the producer's divided-clock cadence.

## Interface
- `DEPTH`, 16: FIFO depth in characters; power of two, ≥2.
- `CHAR_W`, 7: character width (ASCII).

- `clk`  in  1  system clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `inputbits`  in  10  packed sequence: five 2-bit slots, first symbol in [9:8], last in [1:0]; 00 empty, 01 dot, 10 dash, 11 illegal.
- `spa_end`  in  1  qualifier of the sequence: 0 = letter boundary (space key), 1 = end of sequence/word.
- `sent`  in  1  level from producer; each rising edge hands over one sequence.
- `Clear`  in  1  synchronous flush of FIFO, sticky flags and FSM.
- `char_data`  out  CHAR_W  FIFO head character (first-word-fall-through).
- `char_valid`  out  1  FIFO non-empty.
- `char_ready`  in  1  consumer accepts head when `char_valid & char_ready`.
- `fifo_count`  out  log2(DEPTH)+1  stored characters.
- `err`  out  1  sticky: an illegal pattern was decoded.
- `overrun`  out  1  sticky: a sequence or character was dropped.

## Operation
- Edge detect: `sent_q` registers `sent`; edge = `sent & ~sent_q`. `sent_q` resets to 1, so `sent` held high through reset is not an edge.
- FSM states: IDLE, DECODE, PUSH_CHAR, PUSH_SPACE.
  - IDLE: on edge, latch `inputbits` and `spa_end`, go to DECODE.
  - DECODE: registered table lookup producing code, empty, and illegal. Illegal & nonempty goes to PUSH_CHAR with code 0x3F ('?') and sets `err`. Empty with spa_end=1 goes to PUSH_SPACE. Empty with spa_end=0 goes to IDLE with nothing pushed and no error. Otherwise go to PUSH_CHAR.
  - PUSH_CHAR: write code, then go to PUSH_SPACE if spa_end=1, else IDLE.
  - PUSH_SPACE: write 0x20, then go to IDLE.
- Illegal pattern: any slot = 11, any nonzero slot after an empty slot, or a valid-shaped pattern absent from the A–Z/0–9 table.
- Table: international Morse for A–Z (uppercase ASCII 0x41–0x5A) and 0–9 (0x30–0x39).
- Edge seen outside IDLE: sequence dropped, `overrun` set.
- Write while full and no pop that cycle: write dropped, `overrun` set, FSM advances normally.
- Full with pop in the same cycle: write accepted, count unchanged.
- Pop when empty: ignored.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. `fifo_count` ranges 0..DEPTH.
- `Clear`: takes priority over every event that cycle. FSM goes to IDLE, pointers and count go to 0, `err` and `overrun` go to 0, and an edge in the same cycle is discarded. `sent_q` still tracks `sent`.
- Reset values: `char_valid`=0, `char_data`=0, `fifo_count`=0, `err`=0, `overrun`=0, FSM=IDLE, `sent_q`=1.
- Reset mid-operation aborts the sequence with no partial write.

## Timing
- Edge sampled at clock edge k. DECODE holds during k→k+1. PUSH_CHAR writes at edge k+2. `char_valid` is high and `char_data` is valid after edge k+2, so latency is 3 clocks.
- Trailing space is written at edge k+3.
- Busy window is 3 clocks (4 with a space). The producer's divided cadence guarantees ≥10 clocks between edges.
- `char_data` updates the cycle after a pop to the next entry. `char_valid` falls the cycle after the last entry is popped.
- Sticky flags assert the cycle after the causing event.

## Test plan
- Reset with `sent`=1, release `Reset_n` -> no push. All outputs 0, `fifo_count`=0.
- `inputbits`=0x180 (.-), spa_end=0, `sent` rise, `char_ready`=0 -> `char_valid` after 3 clocks, `char_data`=0x41, count 1.
- 0x150 (...), spa_end=1 -> FIFO holds 0x53 then 0x20, count 2. Pop both -> `char_valid`=0.
- 0x2AA (-----) -> 0x30. Then 0x300 -> 0x3F with `err`=1. Then 0x110 -> 0x3F. Then 0x000 with spa_end=0 -> nothing pushed.
- Fill DEPTH chars with `char_ready`=0, send one more -> `overrun`=1, count=DEPTH, head unchanged. Repeat with `char_ready`=1 that cycle -> accepted, no overrun.
- Second `sent` edge one clock after the first -> `overrun`=1, only first char stored. `Clear` with a simultaneous edge -> count 0, flags 0, nothing pushed.

Source files
------------

// File: rtl/morse_sequence_consumer.sv
// Morse sequence consumer: decodes packed dot/dash sequences to ASCII
// and buffers characters in a first-word-fall-through FIFO.
module morse_sequence_consumer #(
    parameter int DEPTH  = 16,
    parameter int CHAR_W = 7
) (
    input  logic                       clk,
    input  logic                       Reset_n,
    input  logic [9:0]                 inputbits,
    input  logic                       spa_end,
    input  logic                       sent,
    input  logic                       Clear,
    output logic [CHAR_W-1:0]          char_data,
    output logic                       char_valid,
    input  logic                       char_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err,
    output logic                       overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, DECODE, PUSH_CHAR, PUSH_SPACE} state_t;

    state_t            state, next;
    logic              sent_q;
    logic              rise;
    logic [9:0]        bits_q;
    logic              spa_q;
    logic [CHAR_W-1:0] code_q;
    logic [6:0]        lut_code;
    logic              lut_bad;
    logic              lut_empty;
    logic              wr_en;
    logic [CHAR_W-1:0] wr_data;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;

    assign rise = sent & ~sent_q;

    // Anything outside the table, including shape violations, is illegal.
    always_comb begin
        lut_code  = 7'h00;
        lut_bad   = 1'b0;
        lut_empty = (bits_q == 10'd0);
        case (bits_q)
            10'b00_00_00_00_00: lut_code = 7'h00;
            10'b01_10_00_00_00: lut_code = 7'h41;
            10'b10_01_01_01_00: lut_code = 7'h42;
            10'b10_01_10_01_00: lut_code = 7'h43;
            10'b10_01_01_00_00: lut_code = 7'h44;
            10'b01_00_00_00_00: lut_code = 7'h45;
            10'b01_01_10_01_00: lut_code = 7'h46;
            10'b10_10_01_00_00: lut_code = 7'h47;
            10'b01_01_01_01_00: lut_code = 7'h48;
            10'b01_01_00_00_00: lut_code = 7'h49;
            10'b01_10_10_10_00: lut_code = 7'h4A;
            10'b10_01_10_00_00: lut_code = 7'h4B;
            10'b01_10_01_01_00: lut_code = 7'h4C;
            10'b10_10_00_00_00: lut_code = 7'h4D;
            10'b10_01_00_00_00: lut_code = 7'h4E;
            10'b10_10_10_00_00: lut_code = 7'h4F;
            10'b01_10_10_01_00: lut_code = 7'h50;
            10'b10_10_01_10_00: lut_code = 7'h51;
            10'b01_10_01_00_00: lut_code = 7'h52;
            10'b01_01_01_00_00: lut_code = 7'h53;
            10'b10_00_00_00_00: lut_code = 7'h54;
            10'b01_01_10_00_00: lut_code = 7'h55;
            10'b01_01_01_10_00: lut_code = 7'h56;
            10'b01_10_10_00_00: lut_code = 7'h57;
            10'b10_01_01_10_00: lut_code = 7'h58;
            10'b10_01_10_10_00: lut_code = 7'h59;
            10'b10_10_01_01_00: lut_code = 7'h5A;
            10'b10_10_10_10_10: lut_code = 7'h30;
            10'b01_10_10_10_10: lut_code = 7'h31;
            10'b01_01_10_10_10: lut_code = 7'h32;
            10'b01_01_01_10_10: lut_code = 7'h33;
            10'b01_01_01_01_10: lut_code = 7'h34;
            10'b01_01_01_01_01: lut_code = 7'h35;
            10'b10_01_01_01_01: lut_code = 7'h36;
            10'b10_10_01_01_01: lut_code = 7'h37;
            10'b10_10_10_01_01: lut_code = 7'h38;
            10'b10_10_10_10_01: lut_code = 7'h39;
            default:            lut_bad  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:       if (rise) next = DECODE;
            DECODE: begin
                if (lut_bad)        next = PUSH_CHAR;
                else if (lut_empty) next = spa_q ? PUSH_SPACE : IDLE;
                else                next = PUSH_CHAR;
            end
            PUSH_CHAR:  next = spa_q ? PUSH_SPACE : IDLE;
            PUSH_SPACE: next = IDLE;
            default:    next = IDLE;
        endcase
        if (Clear) next = IDLE;
    end

    always_comb begin
        wr_en   = (state == PUSH_CHAR) || (state == PUSH_SPACE);
        wr_data = (state == PUSH_CHAR) ? code_q : CHAR_W'(7'h20);
        full    = (count == CW'(DEPTH));
        pop     = char_ready && (count != '0);
        push_ok = wr_en && (!full || pop);
        drop    = wr_en && full && !pop;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sent_q  <= 1'b1;
            bits_q  <= '0;
            spa_q   <= 1'b0;
            code_q  <= '0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            sent_q <= sent;
            if (Clear) begin
                err     <= 1'b0;
                overrun <= 1'b0;
            end else begin
                if (state == IDLE && rise) begin
                    bits_q <= inputbits;
                    spa_q  <= spa_end;
                end
                if (state == DECODE) begin
                    code_q <= lut_bad ? CHAR_W'(7'h3F) : CHAR_W'(lut_code);
                    if (lut_bad) err <= 1'b1;
                end
                if ((rise && state != IDLE) || drop) overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    assign char_valid = (count != '0);
    assign char_data  = char_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;
endmodule

// File: tb/tb_morse_sequence_consumer.sv
// Directed bench for morse_sequence_consumer with hand-computed
// expected characters, counts and flags.
module tb_morse_sequence_consumer;
    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] inputbits = '0;
    logic       spa_end = 1'b0;
    logic       sent = 1'b1;
    logic       Clear = 1'b0;
    logic [6:0] char_data;
    logic       char_valid;
    logic       char_ready = 1'b0;
    logic [4:0] fifo_count;
    logic       err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    morse_sequence_consumer #(.DEPTH(16), .CHAR_W(7)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .inputbits  (inputbits),
        .spa_end    (spa_end),
        .sent       (sent),
        .Clear      (Clear),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .fifo_count (fifo_count),
        .err        (err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One producer handover; optionally pop exactly on the char write edge.
    task automatic send(input logic [9:0] b, input logic s,
                        input logic pop_w);
        @(negedge clk);
        inputbits = b;
        spa_end   = s;
        sent      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (pop_w) char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
        repeat (2) @(negedge clk);
        sent = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pop1();
        @(negedge clk);
        char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
    endtask

    task automatic clear1();
        @(negedge clk);
        Clear = 1'b1;
        @(negedge clk);
        Clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", char_valid, 1'b0);
        check("rst_data", char_data, 7'h00);
        check("rst_count", fifo_count, 5'd0);
        check("rst_err", err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        sent = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nopush", fifo_count, 5'd0);

        // Latency: edge sampled at k, char visible after k+2.
        inputbits = 10'h180;
        spa_end   = 1'b0;
        sent      = 1'b1;
        @(negedge clk);
        check("lat_k", char_valid, 1'b0);
        @(negedge clk);
        check("lat_k1", char_valid, 1'b0);
        @(negedge clk);
        check("lat_k2", char_valid, 1'b1);
        check("a_data", char_data, 7'h41);
        check("a_count", fifo_count, 5'd1);
        repeat (3) @(negedge clk);
        sent = 1'b0;
        repeat (5) @(negedge clk);
        pop1();
        check("a_popped", fifo_count, 5'd0);

        send(10'h150, 1'b1, 1'b0);
        check("s_count", fifo_count, 5'd2);
        check("s_data", char_data, 7'h53);
        pop1();
        check("sp_data", char_data, 7'h20);
        pop1();
        check("drain_valid", char_valid, 1'b0);
        pop1();
        check("empty_pop", fifo_count, 5'd0);

        send(10'h2AA, 1'b0, 1'b0);
        check("zero_data", char_data, 7'h30);
        check("zero_err", err, 1'b0);
        send(10'h300, 1'b0, 1'b0);
        check("ill11_err", err, 1'b1);
        check("ill11_cnt", fifo_count, 5'd2);
        pop1();
        check("ill11_data", char_data, 7'h3F);
        pop1();
        send(10'h110, 1'b0, 1'b0);
        check("gap_data", char_data, 7'h3F);
        check("gap_cnt", fifo_count, 5'd1);
        send(10'h000, 1'b0, 1'b0);
        check("empty_cnt", fifo_count, 5'd1);
        check("empty_ovr", overrun, 1'b0);
        clear1();
        check("clr_cnt", fifo_count, 5'd0);
        check("clr_err", err, 1'b0);

        // Fill to full, then overflow without a pop.
        send(10'h180, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) send(10'h100, 1'b0, 1'b0);
        check("full_cnt", fifo_count, 5'd16);
        check("full_ovr0", overrun, 1'b0);
        send(10'h200, 1'b0, 1'b0);
        check("ovf_ovr", overrun, 1'b1);
        check("ovf_cnt", fifo_count, 5'd16);
        check("ovf_head", char_data, 7'h41);

        // Full with a simultaneous pop accepts the write.
        clear1();
        send(10'h180, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) send(10'h100, 1'b0, 1'b0);
        send(10'h200, 1'b0, 1'b1);
        check("fp_cnt", fifo_count, 5'd16);
        check("fp_ovr", overrun, 1'b0);
        check("fp_head", char_data, 7'h45);
        for (int i = 0; i < 15; i++) pop1();
        check("fp_tail", char_data, 7'h54);

        // Second edge while busy is dropped.
        clear1();
        @(negedge clk);
        inputbits = 10'h180;
        sent = 1'b1;
        @(negedge clk);
        sent = 1'b0;
        inputbits = 10'h200;
        @(negedge clk);
        sent = 1'b1;
        repeat (4) @(negedge clk);
        sent = 1'b0;
        repeat (6) @(negedge clk);
        check("dbl_ovr", overrun, 1'b1);
        check("dbl_cnt", fifo_count, 5'd1);
        check("dbl_data", char_data, 7'h41);

        // Clear wins over a same-cycle edge.
        @(negedge clk);
        inputbits = 10'h180;
        sent  = 1'b1;
        Clear = 1'b1;
        @(negedge clk);
        Clear = 1'b0;
        repeat (6) @(negedge clk);
        check("ce_cnt", fifo_count, 5'd0);
        check("ce_valid", char_valid, 1'b0);
        check("ce_ovr", overrun, 1'b0);
        check("ce_err", err, 1'b0);
        sent = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
